// File: rtl/nibble_serial_adder.sv
// Multi-nibble adder controller: feeds one nibble per cycle to an external
// 4-bit ripple-carry adder and chains its carry through a register.
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   cin,
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_cin,
  input  logic [3:0]             add_s,
  input  logic                   add_cout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout,
  output logic                   ovf
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [W-1:0]       sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               carry_q, carry_d;
  logic [IDX_W-1:0]   nib_idx_q, nib_idx_d;
  logic [IDX_W+1:0]   bit_base;

  // Bit offset of the current nibble, kept narrow so the part-selects stay width-clean.
  assign bit_base = {nib_idx_q, 2'b00};

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    carry_d   = carry_q;
    nib_idx_d = nib_idx_q;
    add_a     = 4'h0;
    add_b     = 4'h0;
    add_cin   = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d       = a;
          b_d       = b;
          carry_d   = cin;
          nib_idx_d = '0;
          sum_d     = '0;
          state_d   = RUN;
        end
      end

      RUN: begin
        add_a   = a_q[bit_base +: 4];
        add_b   = b_q[bit_base +: 4];
        add_cin = carry_q;

        sum_d[bit_base +: 4] = add_s;
        carry_d              = add_cout;

        // Signed overflow only needs the operand sign bits and the top nibble's sum MSB.
        if (nib_idx_q == LAST_IDX) begin
          cout_d  = add_cout;
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (add_s[3] != a_q[W-1]);
          state_d = DONE;
        end else begin
          nib_idx_d = nib_idx_q + 1'b1;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      carry_q   <= 1'b0;
      nib_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      ovf_q     <= ovf_d;
      carry_q   <= carry_d;
      nib_idx_q <= nib_idx_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder with a behavioural 4-bit adder
// and an arithmetic reference model of the multi-nibble result.
module tb_nibble_serial_adder;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          cin;
  logic [3:0]    add_a;
  logic [3:0]    add_b;
  logic          add_cin;
  logic [3:0]    add_s;
  logic          add_cout;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  sum;
  logic          cout;
  logic          ovf;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  bit busy = 1'b0;
  logic [W-1:0] cur_a;
  logic [W-1:0] cur_b;
  logic         cur_cin;
  exp_t exp_q[$];

  nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_s     (add_s),
    .add_cout  (add_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  // Behavioural stand-in for the external fulladd4.
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic exp_t modelResult(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    exp_t r;
    longint unsigned full;
    longint sa, sb, ss;
    full   = longint'(av) + longint'(bv) + longint'(cv);
    r.sum  = full[W-1:0];
    r.cout = full[W];
    sa = av[W-1] ? longint'(av) - (64'sd1 <<< W) : longint'(av);
    sb = bv[W-1] ? longint'(bv) - (64'sd1 <<< W) : longint'(bv);
    ss = sa + sb + longint'(cv);
    r.ovf = (ss > ((64'sd1 <<< (W-1)) - 1)) || (ss < -(64'sd1 <<< (W-1)));
    return r;
  endfunction

  function automatic logic [3:0] nibbleOf(input logic [W-1:0] v, input int k);
    longint unsigned t;
    t = longint'(v) >> (4 * k);
    return t[3:0];
  endfunction

  function automatic logic carryInto(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv, input int k);
    longint unsigned m, t;
    m = (64'd1 << (4 * k)) - 1;
    t = (longint'(av) & m) + (longint'(bv) & m) + longint'(cv);
    t = t >> (4 * k);
    return t[0];
  endfunction

  // Monitor: samples on the falling edge, checks per-nibble drive during RUN and pops on handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy && cyc >= acc_cyc) begin
        int k;
        k = cyc - acc_cyc;
        if (k < NIBBLES) begin
          checkOutput("run_add_a", 64'(add_a), 64'(nibbleOf(cur_a, k)));
          checkOutput("run_add_b", 64'(add_b), 64'(nibbleOf(cur_b, k)));
          checkOutput("run_add_cin", 64'(add_cin), 64'(carryInto(cur_a, cur_b, cur_cin, k)));
          checkOutput("run_in_ready", 64'(in_ready), 64'd0);
          checkOutput("run_out_valid", 64'(out_valid), 64'd0);
        end else begin
          checkOutput("done_out_valid", 64'(out_valid), 64'd1);
          checkOutput("done_in_ready", 64'(in_ready), 64'd0);
          checkOutput("done_add_a", 64'(add_a), 64'd0);
          checkOutput("done_add_cin", 64'(add_cin), 64'd0);
          if (exp_q.size() == 0) begin
            checkOutput("scoreboard_empty", 64'd1, 64'd0);
          end else begin
            checkOutput("sum", 64'(sum), 64'(exp_q[0].sum));
            checkOutput("cout", 64'(cout), 64'(exp_q[0].cout));
            checkOutput("ovf", 64'(ovf), 64'(exp_q[0].ovf));
            if (out_valid && out_ready) begin
              void'(exp_q.pop_front());
              busy = 1'b0;
            end
          end
        end
      end else if (!busy) begin
        checkOutput("idle_in_ready", 64'(in_ready), 64'd1);
        checkOutput("idle_out_valid", 64'(out_valid), 64'd0);
      end
    end
  end

  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                               input bit hold, output int acc);
    a        = av;
    b        = bv;
    cin      = cv;
    in_valid = 1'b1;
    acc      = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready && !rst) begin
        acc     = cyc + 1;
        cur_a   = av;
        cur_b   = bv;
        cur_cin = cv;
        exp_q.push_back(modelResult(av, bv, cv));
        acc_cyc = acc;
        busy    = 1'b1;
        break;
      end
    end
    if (acc < 0) checkOutput("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic waitIdle(input bit rand_bp);
    for (int i = 0; i < 200 && busy; i++) begin
      @(posedge clk);
      #1;
      if (rand_bp) out_ready = 1'($urandom_range(0, 1));
    end
    if (busy) begin
      checkOutput("done_timeout", 64'd0, 64'd1);
      busy = 1'b0;
      exp_q.delete();
    end
    out_ready = 1'b1;
  endtask

  initial begin
    int acc1, acc2;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_sum", 64'(sum), 64'd0);
    checkOutput("reset_cout", 64'(cout), 64'd0);
    checkOutput("reset_ovf", 64'(ovf), 64'd0);
    checkOutput("reset_add_a", 64'(add_a), 64'd0);

    applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b0, acc1);
    waitIdle(1'b0);
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, acc1);
    waitIdle(1'b0);
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0, acc1);
    waitIdle(1'b0);
    applyStimulus(16'h8000, 16'h8000, 1'b0, 1'b0, acc1);
    waitIdle(1'b0);
    applyStimulus(16'h00FF, 16'h0000, 1'b1, 1'b0, acc1);
    waitIdle(1'b0);

    // Backpressure in DONE with a stray in_valid pulse that must be ignored.
    out_ready = 1'b0;
    applyStimulus(16'h0123, 16'h0456, 1'b0, 1'b0, acc1);
    repeat (NIBBLES) @(posedge clk);
    #1;
    a        = 16'hAAAA;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 out_ready = 1'b1;
    waitIdle(1'b0);
    checkOutput("bp_in_ready_after", 64'(in_ready), 64'd1);

    // Abort mid-RUN: reset is sampled on the second RUN edge.
    applyStimulus(16'h1111, 16'h2222, 1'b0, 1'b0, acc1);
    @(posedge clk);
    #1;
    rst  = 1'b1;
    busy = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("abort_in_ready", 64'(in_ready), 64'd1);
    checkOutput("abort_out_valid", 64'(out_valid), 64'd0);
    checkOutput("abort_sum", 64'(sum), 64'd0);
    checkOutput("abort_cout", 64'(cout), 64'd0);
    repeat (8) @(posedge clk);
    #1;

    // Back-to-back with in_valid held high.
    applyStimulus(16'h0001, 16'h0001, 1'b0, 1'b1, acc1);
    applyStimulus(16'h0F0F, 16'h00F1, 1'b0, 1'b0, acc2);
    checkOutput("b2b_accept_spacing", 64'(acc2 - acc1), 64'(NIBBLES + 2));
    waitIdle(1'b0);

    for (int n = 0; n < 30; n++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      if (n % 7 == 0) rb = ~ra;
      applyStimulus(ra, rb, 1'($urandom_range(0, 1)), 1'b0, acc1);
      waitIdle(1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
